// File: rtl/mem_access_unit.sv
// Memory access unit sitting between the EX/MEM pipeline register and the
// data memory. Aligned requests pass straight through in one cycle. With
// SPLIT_EN set, misaligned half/word requests are broken into byte accesses
// over consecutive cycles while the pipeline is stalled. Without SPLIT_EN
// they are rejected with an error pulse.
module mem_access_unit #(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_ctrl,
    input  logic        req_wr,
    input  logic        flush,
    output logic [31:0] address,
    output logic [31:0] dataWr,
    output logic [2:0]  dmCtrl,
    output logic        dmWr,
    input  logic [31:0] dataRd,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        done,
    output logic        err
);

    typedef enum logic {
        IDLE,
        SPLIT
    } stateT;

    // Byte-access encodings used while splitting a request.
    localparam logic [2:0] CTRL_SB  = 3'b000;
    localparam logic [2:0] CTRL_LBU = 3'b100;

    stateT       state;
    logic [1:0]  cnt;
    logic [31:0] baseQ;
    logic [31:0] dataQ;
    logic [31:0] asmQ;
    logic        halfQ;
    logic        unsignedQ;
    logic        wrQ;

    logic        active;
    logic        legal;
    logic        aligned;
    logic        splitLast;
    logic [7:0]  storeByte;
    logic [31:0] asmNext;
    logic [31:0] splitResult;

    // Classify the incoming request: legal encoding and natural alignment.
    always_comb begin
        active  = req_valid && !flush;
        legal   = 1'b0;
        aligned = 1'b0;
        case (req_ctrl)
            3'b000, 3'b100: begin
                legal   = 1'b1;
                aligned = 1'b1;
            end
            3'b001, 3'b101: begin
                legal   = 1'b1;
                aligned = (req_addr[0] == 1'b0);
            end
            3'b010: begin
                legal   = 1'b1;
                aligned = (req_addr[1:0] == 2'b00);
            end
            default: begin
                legal   = 1'b0;
                aligned = 1'b0;
            end
        endcase
    end

    // Split bookkeeping: last byte detection, store byte select and the
    // assembled load value including the byte arriving this cycle.
    always_comb begin
        splitLast = halfQ ? (cnt == 2'd1) : (cnt == 2'd3);
        storeByte = dataQ[{cnt, 3'b000} +: 8];
        asmNext   = asmQ;
        asmNext[{cnt, 3'b000} +: 8] = dataRd[7:0];
        if (!halfQ) begin
            splitResult = asmNext;
        end else if (unsignedQ) begin
            splitResult = {16'h0000, asmNext[15:0]};
        end else begin
            splitResult = {{16{asmNext[15]}}, asmNext[15:0]};
        end
    end

    // Memory-side outputs for the access issued this cycle; reset forces the
    // write enable and stall low without waiting for a clock edge.
    always_comb begin
        address = req_addr;
        dataWr  = req_wdata;
        dmCtrl  = req_ctrl;
        dmWr    = 1'b0;
        stall   = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (active && legal) begin
                        if (aligned) begin
                            dmWr = req_wr;
                        end else if (SPLIT_EN) begin
                            dmCtrl = req_wr ? CTRL_SB : CTRL_LBU;
                            dataWr = {24'h000000, req_wdata[7:0]};
                            dmWr   = req_wr;
                            stall  = 1'b1;
                        end
                    end
                end
                SPLIT: begin
                    address = baseQ + {30'b0, cnt};
                    dmCtrl  = wrQ ? CTRL_SB : CTRL_LBU;
                    dataWr  = {24'h000000, storeByte};
                    if (!flush) begin
                        dmWr  = wrQ;
                        stall = !splitLast;
                    end
                end
                default: begin
                    dmWr  = 1'b0;
                    stall = 1'b0;
                end
            endcase
        end
    end

    // Request sequencing: completes aligned accesses, latches misaligned ones
    // and walks their bytes, and produces the done/err pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            baseQ     <= 32'h0;
            dataQ     <= 32'h0;
            asmQ      <= 32'h0;
            halfQ     <= 1'b0;
            unsignedQ <= 1'b0;
            wrQ       <= 1'b0;
            load_data <= 32'h0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (active) begin
                        if (!legal || (!aligned && !SPLIT_EN)) begin
                            err <= 1'b1;
                        end else if (aligned) begin
                            done <= 1'b1;
                            if (!req_wr) begin
                                load_data <= dataRd;
                            end
                        end else begin
                            baseQ     <= req_addr;
                            dataQ     <= req_wdata;
                            halfQ     <= (req_ctrl[1:0] == 2'b01);
                            unsignedQ <= req_ctrl[2];
                            wrQ       <= req_wr;
                            asmQ      <= {24'h000000, dataRd[7:0]};
                            cnt       <= 2'd1;
                            state     <= SPLIT;
                        end
                    end
                end
                SPLIT: begin
                    if (flush) begin
                        cnt   <= 2'd0;
                        state <= IDLE;
                    end else begin
                        asmQ <= asmNext;
                        if (splitLast) begin
                            cnt   <= 2'd0;
                            state <= IDLE;
                            done  <= 1'b1;
                            if (!wrQ) begin
                                load_data <= splitResult;
                            end
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                end
                default: begin
                    cnt   <= 2'd0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-wide data memory model
// that reads combinationally and sign/zero-extends per dmCtrl.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_ctrl;
    logic        req_wr;
    logic        flush;
    logic [31:0] address;
    logic [31:0] dataWr;
    logic [2:0]  dmCtrl;
    logic        dmWr;
    logic [31:0] dataRd;
    logic        stall;
    logic [31:0] load_data;
    logic        done;
    logic        err;

    logic [7:0]  mem [256];
    int          numChecks;
    int          numPassed;

    mem_access_unit #(.SPLIT_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ctrl  (req_ctrl),
        .req_wr    (req_wr),
        .flush     (flush),
        .address   (address),
        .dataWr    (dataWr),
        .dmCtrl    (dmCtrl),
        .dmWr      (dmWr),
        .dataRd    (dataRd),
        .stall     (stall),
        .load_data (load_data),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Initial memory image, reloaded whenever reset is held across an edge.
    function automatic logic [7:0] initByte(input int idx);
        case (idx)
            8'h30: initByte = 8'h78;
            8'h31: initByte = 8'h56;
            8'h32: initByte = 8'h34;
            8'h33: initByte = 8'h12;
            8'h21: initByte = 8'hDE;
            8'h22: initByte = 8'hBC;
            8'hFE: initByte = 8'h11;
            8'hFF: initByte = 8'h22;
            8'h00: initByte = 8'h33;
            8'h01: initByte = 8'h44;
            default: initByte = 8'h00;
        endcase
    endfunction

    // Memory writes (sized by dmCtrl) and image reload during reset.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= initByte(i);
        end else if (dmWr) begin
            case (dmCtrl[1:0])
                2'b00: mem[address[7:0]] <= dataWr[7:0];
                2'b01: begin
                    mem[address[7:0]]         <= dataWr[7:0];
                    mem[address[7:0] + 8'd1]  <= dataWr[15:8];
                end
                2'b10: begin
                    mem[address[7:0]]         <= dataWr[7:0];
                    mem[address[7:0] + 8'd1]  <= dataWr[15:8];
                    mem[address[7:0] + 8'd2]  <= dataWr[23:16];
                    mem[address[7:0] + 8'd3]  <= dataWr[31:24];
                end
                default: ;
            endcase
        end
    end

    // Combinational memory read with extension per dmCtrl.
    always_comb begin
        logic [7:0] b0, b1, b2, b3;
        b0 = mem[address[7:0]];
        b1 = mem[address[7:0] + 8'd1];
        b2 = mem[address[7:0] + 8'd2];
        b3 = mem[address[7:0] + 8'd3];
        case (dmCtrl)
            3'b000:  dataRd = {{24{b0[7]}}, b0};
            3'b100:  dataRd = {24'h000000, b0};
            3'b001:  dataRd = {{16{b1[7]}}, b1, b0};
            3'b101:  dataRd = {16'h0000, b1, b0};
            3'b010:  dataRd = {b3, b2, b1, b0};
            default: dataRd = 32'h0;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numChecks++;
        if (observed === expected) begin
            numPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] d,
                                 input logic [2:0] c, input logic w, input logic f);
        req_valid = v;
        req_addr  = a;
        req_wdata = d;
        req_ctrl  = c;
        req_wr    = w;
        flush     = f;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one request for n cycles, checking the issued address, store
    // byte, write enable, stall and done on each cycle. Request inputs are
    // scrambled after the first cycle since the latched copy must be used.
    task automatic runAccess(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [2:0] c, input logic w, input int n);
        logic [31:0] expData;
        applyStimulus(1'b1, a, d, c, w, 1'b0);
        for (int i = 0; i < n; i++) begin
            #2;
            checkOutput({tag, ".addr"}, address, a + i);
            checkOutput({tag, ".dmWr"}, {31'b0, dmWr}, {31'b0, w});
            checkOutput({tag, ".stall"}, {31'b0, stall}, {31'b0, (i < n - 1)});
            if (w) begin
                expData = (n == 1) ? d : ((d >> (8 * i)) & 32'hFF);
                checkOutput({tag, ".dataWr"}, dataWr, expData);
            end
            tick();
            checkOutput({tag, ".done"}, {31'b0, done}, {31'b0, (i == n - 1)});
            if (i == 0) begin
                req_addr  = 32'hDEAD0000;
                req_wdata = 32'h0;
            end
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0);
    endtask

    initial begin
        numChecks = 0;
        numPassed = 0;
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("rst.done", {31'b0, done}, 32'h0);
        checkOutput("rst.err", {31'b0, err}, 32'h0);
        checkOutput("rst.stall", {31'b0, stall}, 32'h0);
        checkOutput("rst.dmWr", {31'b0, dmWr}, 32'h0);
        checkOutput("rst.loadData", load_data, 32'h0);
        rst = 1'b0;

        runAccess("lw30", 32'h30, 32'h0, 3'b010, 1'b0, 1);
        checkOutput("lw30.data", load_data, 32'h12345678);

        runAccess("sw40", 32'h40, 32'hCAFEF00D, 3'b010, 1'b1, 1);
        checkOutput("sw40.keep", load_data, 32'h12345678);
        checkOutput("sw40.mem", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'hCAFEF00D);

        runAccess("sw6e", 32'h6E, 32'hAABBCCDD, 3'b010, 1'b1, 4);
        checkOutput("sw6e.keep", load_data, 32'h12345678);
        checkOutput("sw6e.mem", {mem[8'h71], mem[8'h70], mem[8'h6F], mem[8'h6E]}, 32'hAABBCCDD);

        runAccess("lh21", 32'h21, 32'h0, 3'b001, 1'b0, 2);
        checkOutput("lh21.data", load_data, 32'hFFFFBCDE);
        runAccess("lhu21", 32'h21, 32'h0, 3'b101, 1'b0, 2);
        checkOutput("lhu21.data", load_data, 32'h0000BCDE);
        runAccess("lwWrap", 32'hFFFFFFFE, 32'h0, 3'b010, 1'b0, 4);
        checkOutput("lwWrap.data", load_data, 32'h44332211);

        // Illegal encoding on a store
        applyStimulus(1'b1, 32'h50, 32'h11, 3'b011, 1'b1, 1'b0);
        #2;
        checkOutput("ill.dmWr", {31'b0, dmWr}, 32'h0);
        checkOutput("ill.stall", {31'b0, stall}, 32'h0);
        tick();
        checkOutput("ill.err", {31'b0, err}, 32'h1);
        checkOutput("ill.done", {31'b0, done}, 32'h0);
        checkOutput("ill.keep", load_data, 32'h44332211);
        applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0);
        tick();
        checkOutput("ill.errPulse", {31'b0, err}, 32'h0);

        // Flush in IDLE beats a valid store
        applyStimulus(1'b1, 32'h50, 32'h1234, 3'b010, 1'b1, 1'b1);
        #2;
        checkOutput("flushIdle.dmWr", {31'b0, dmWr}, 32'h0);
        tick();
        checkOutput("flushIdle.done", {31'b0, done}, 32'h0);
        checkOutput("flushIdle.err", {31'b0, err}, 32'h0);
        checkOutput("flushIdle.mem", {24'h0, mem[8'h50]}, 32'h0);

        // Reset in the middle of a split word load
        applyStimulus(1'b1, 32'hFFFFFFFE, 32'h0, 3'b010, 1'b0, 1'b0);
        tick();
        #2;
        checkOutput("rstMid.stallBefore", {31'b0, stall}, 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("rstMid.stall", {31'b0, stall}, 32'h0);
        checkOutput("rstMid.dmWr", {31'b0, dmWr}, 32'h0);
        checkOutput("rstMid.loadData", load_data, 32'h0);
        checkOutput("rstMid.done", {31'b0, done}, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0);
        tick();
        rst = 1'b0;

        // Split store killed by flush on its third byte
        applyStimulus(1'b1, 32'h6E, 32'hAABBCCDD, 3'b010, 1'b1, 1'b0);
        #2;
        checkOutput("swFlush.dmWr0", {31'b0, dmWr}, 32'h1);
        tick();
        #2;
        checkOutput("swFlush.dmWr1", {31'b0, dmWr}, 32'h1);
        tick();
        flush = 1'b1;
        #2;
        checkOutput("swFlush.dmWr2", {31'b0, dmWr}, 32'h0);
        tick();
        checkOutput("swFlush.done", {31'b0, done}, 32'h0);
        checkOutput("swFlush.mem", {mem[8'h71], mem[8'h70], mem[8'h6F], mem[8'h6E]}, 32'h0000CCDD);
        applyStimulus(1'b1, 32'h21, 32'h0, 3'b001, 1'b0, 1'b0);
        #2;
        checkOutput("swFlush.idleAddr", address, 32'h21);
        checkOutput("swFlush.idleCtrl", {29'b0, dmCtrl}, 32'h4);
        tick();
        tick();
        checkOutput("swFlush.nextDone", {31'b0, done}, 32'h1);
        checkOutput("swFlush.nextData", load_data, 32'hFFFFBCDE);
        applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0);
        tick();

        $display("%0d/%0d checks passed", numPassed, numChecks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter: SPLIT_EN, 1, 1 = misaligned half/word accesses split into byte accesses; 0 = misaligned flagged as error, no access.
REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  EX/MEM holds a memory request.
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data (rs2).
- req_ctrl  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_wr  in  1  1 = store, 0 = load.
- flush  in  1  kill current request.
- address  out  32  to data_memory address.
- dataWr  out  32  to data_memory dataWr.
- dmCtrl  out  3  to data_memory dmCtrl.
- dmWr  out  1  to data_memory dmWr.
- dataRd  in  32  from data_memory (combinational read, already extended per dmCtrl).
- stall  out  1  pipeline SHALL hold EX/MEM and earlier stages at this edge.
- load_data  out  32  registered load result.
- done  out  1  one-cycle pulse: request complete; load_data valid.
- err  out  1  one-cycle pulse: illegal req_ctrl, or misaligned with SPLIT_EN=0.

Function
REQ-003 SHALL use an FSM with states IDLE and SPLIT, plus registered byte counter cnt (2 bits), latched base address, data, size, signedness and direction.
REQ-004 Aligned = byte any address; half addr[0]=0; word addr[1:0]=00.
REQ-005 IDLE, req_valid, legal, aligned: address/dataWr/dmCtrl = req values; dmWr = req_wr; stall=0; at the edge load_data <= dataRd (loads only), done <= 1.
REQ-006 IDLE, req_valid, legal, misaligned, SPLIT_EN=1: stall=1; issue byte 0 at req_addr (dmCtrl 000 store, 100 load, dataWr[7:0] = req_wdata[7:0]); latch request; cnt <= 1; go SPLIT.
REQ-007 SPLIT: issue byte cnt at base+cnt (modulo 2^32), store byte = data[8*cnt+7:8*cnt], load byte captured into assembly byte cnt; cnt increments each cycle.
REQ-008 stall SHALL be 1 in SPLIT except the last byte cycle (cnt=1 for half, cnt=3 for word); total 2 cycles half, 4 cycles word; stall high 1 and 3 cycles respectively.
REQ-009 After the last byte edge: go IDLE, done=1; load_data = little-endian assembly, sign-extended for 001, zero-extended for 101; word unchanged.
REQ-010 Illegal req_ctrl (011, 110, 111) or misaligned with SPLIT_EN=0: dmWr=0, err=1 next cycle, done=0, stall=0, load_data unchanged.
REQ-011 dmWr SHALL never be 1 unless a legal store byte/half/word is being issued this cycle.
REQ-012 flush in IDLE: no access issued (dmWr=0), no done/err, even with req_valid high; flush wins.
REQ-013 flush in SPLIT: current cycle dmWr=0, return IDLE, no done; bytes already stored remain.
REQ-014 Stores: done pulses; load_data unchanged.
REQ-015 Request inputs are ignored while in SPLIT; latched copy is used.
REQ-016 Back-to-back aligned requests SHALL complete one per cycle, no bubbles.

Reset
REQ-017 rst=1 SHALL immediately force state IDLE, cnt=0, load_data=0, done=0, err=0, stall=0, dmWr=0, regardless of clk; reset mid-SPLIT aborts, partial stores remain.

Verification
REQ-018 Aligned LW 0x30 holding 0x12345678 -> one cycle, stall=0, done, load_data=0x12345678.
REQ-019 SW 0x6E data 0xAABBCCDD -> byte writes DD@6E, CC@6F, BB@70, AA@71 on 4 consecutive cycles, stall high 3 cycles, done after 4th.
REQ-020 Bytes 0x21=DE, 0x22=BC: LH 0x21 -> load_data 0xFFFFBCDE; LHU 0x21 -> 0x0000BCDE; 2 cycles each.
REQ-021 LW 0xFFFFFFFE -> byte reads at FFFFFFFE, FFFFFFFF, 00000000, 00000001 (wrap).
REQ-022 SW 0x6E with flush in 3rd cycle -> only DD@6E, CC@6F written, no done, IDLE next cycle.
REQ-023 req_ctrl=011 store -> dmWr stays 0, err pulse; rst asserted mid-split word load -> outputs zero without clock edge.
